// File: rtl/mips32_dmem_responder.sv
// Timed data-memory responder for the pipe_MIPS32 MEM stage: LW/SW over valid/ready with WAIT_CYCLES wait states.
// Optional build macro DMEM_STATS_EN adds saturating load/store/error counters.
module mips32_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_was_store
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [7:0]        stat_errs
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    logic [31:0] Mem [0:DEPTH-1];

    state_t            state_r, state_nxt_s;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              req_ready_r, rsp_valid_r, rsp_err_r, rsp_was_store_r;
    logic [31:0]       rsp_rdata_r;
    logic              accept_s, hs_s, in_range_s;
    logic [IDX_W-1:0]  idx_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign hs_s       = (state_r == ST_RESP) && rsp_ready;
    assign in_range_s = ({1'b0, addr_r} < DEPTH_W);
    assign idx_s      = addr_r[IDX_W-1:0];

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_err       = rsp_err_r;
    assign rsp_was_store = rsp_was_store_r;

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, request capture and handshake outputs; ready/valid are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                cnt_r   <= WAIT_L;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Response payload: loaded in ACCESS, held through RESP; only the error flag clears on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r     <= 32'd0;
            rsp_err_r       <= 1'b0;
            rsp_was_store_r <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            rsp_was_store_r <= we_r;
            rsp_err_r       <= !in_range_s;
            rsp_rdata_r     <= (in_range_s && !we_r) ? Mem[idx_s] : 32'd0;
        end else if (hs_s) begin
            rsp_err_r <= 1'b0;
        end
    end

    // Array write; the array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if ((state_r == ST_ACCESS) && we_r && in_range_s) begin
            Mem[idx_s] <= wdata_r;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads_r, stat_stores_r;
    logic [7:0]  stat_errs_r;

    assign stat_loads  = stat_loads_r;
    assign stat_stores = stat_stores_r;
    assign stat_errs   = stat_errs_r;

    // Saturating completion counters; out-of-range loads count both as loads and as errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads_r  <= 16'd0;
            stat_stores_r <= 16'd0;
            stat_errs_r   <= 8'd0;
        end else if (hs_s) begin
            if (!rsp_was_store_r && (stat_loads_r != 16'hFFFF)) begin
                stat_loads_r <= stat_loads_r + 16'd1;
            end
            if (rsp_was_store_r && (stat_stores_r != 16'hFFFF)) begin
                stat_stores_r <= stat_stores_r + 16'd1;
            end
            if (rsp_err_r && (stat_errs_r != 8'hFF)) begin
                stat_errs_r <= stat_errs_r + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Directed self-checking bench for mips32_dmem_responder (DEPTH=1024, ADDR_W=11 so address 1024 is expressible).
module tb_mips32_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_was_store;
`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads, stat_stores;
    logic [7:0]  stat_errs;
`endif

    int tests = 0;
    int fails = 0;
    int lat;
    logic seen_valid;

    mips32_dmem_responder #(.DEPTH(1024), .ADDR_W(11), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_was_store(rsp_was_store)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one request, returns with outputs sampled #1 after the edge where rsp_valid rose.
    // lat counts edges inclusively, the acceptance edge being edge 1.
    task automatic issue(input logic we, input logic [10:0] addr, input logic [31:0] wd, output int l);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        l = 1;
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 11'd0; req_wdata = 32'd0;
        while (!rsp_valid && l < 50) begin
            @(posedge clk);
            l++;
            #1;
        end
    endtask

    task automatic complete(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 11'd0;
        req_wdata = 32'd0; rsp_ready = 1'b1;
        dut.Mem[120] = 32'd85;
        dut.Mem[121] = 32'd0;
        dut.Mem[50]  = 32'd7;
        dut.Mem[476] = 32'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_was_store", {31'd0, rsp_was_store}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load of a preloaded word, rsp_ready held high.
        issue(1'b0, 11'd120, 32'd0, lat);
        check("ld120_latency", 32'(lat), 32'd4);
        check("ld120_rdata", rsp_rdata, 32'd85);
        check("ld120_err", {31'd0, rsp_err}, 32'd0);
        check("ld120_was_store", {31'd0, rsp_was_store}, 32'd0);
        complete("ld120");

        // Store then load back.
        issue(1'b1, 11'd121, 32'd130, lat);
        check("st121_latency", 32'(lat), 32'd4);
        check("st121_rdata", rsp_rdata, 32'd0);
        check("st121_was_store", {31'd0, rsp_was_store}, 32'd1);
        check("st121_err", {31'd0, rsp_err}, 32'd0);
        complete("st121");
        issue(1'b0, 11'd121, 32'd0, lat);
        check("ld121_rdata", rsp_rdata, 32'd130);
        check("ld121_was_store", {31'd0, rsp_was_store}, 32'd0);
        complete("ld121");
        check("mem120_kept", dut.Mem[120], 32'd85);

        // Out-of-range load and store.
        issue(1'b0, 11'd1024, 32'd0, lat);
        check("oor_ld_err", {31'd0, rsp_err}, 32'd1);
        check("oor_ld_rdata", rsp_rdata, 32'd0);
        complete("oor_ld");
        check("oor_ld_err_clear", {31'd0, rsp_err}, 32'd0);
        issue(1'b1, 11'd1500, 32'd999, lat);
        check("oor_st_err", {31'd0, rsp_err}, 32'd1);
        check("oor_st_was_store", {31'd0, rsp_was_store}, 32'd1);
        complete("oor_st");
        check("oor_st_no_alias", dut.Mem[476], 32'h1234);
        issue(1'b0, 11'd120, 32'd0, lat);
        check("after_oor_err", {31'd0, rsp_err}, 32'd0);
        check("after_oor_rdata", rsp_rdata, 32'd85);
        complete("after_oor");

        // Response back-pressure, with a competing request that must be ignored.
        rsp_ready = 1'b0;
        issue(1'b0, 11'd121, 32'd0, lat);
        check("stall_latency", 32'(lat), 32'd4);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd120; req_wdata = 32'd999;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'd130);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        complete("stall");
        check("stall_ignored_req", dut.Mem[120], 32'd85);

        // Reset during WAIT of a store drops it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd50; req_wdata = 32'd999;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk);
        #1;
        check("wait_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_was_store", {31'd0, rsp_was_store}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("midrst_no_rsp", {31'd0, seen_valid}, 32'd0);
        check("midrst_mem50", dut.Mem[50], 32'd7);

        // Normal operation after the aborted transaction.
        issue(1'b0, 11'd50, 32'd0, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_rdata", rsp_rdata, 32'd7);
        complete("post_rst");

`ifdef DMEM_STATS_EN
        // Counters were cleared by the reset above; one more load was just completed.
        issue(1'b0, 11'd120, 32'd0, lat);
        complete("stat_ld1");
        issue(1'b1, 11'd200, 32'd11, lat);
        complete("stat_st0");
        issue(1'b0, 11'd121, 32'd0, lat);
        complete("stat_ld2");
        issue(1'b1, 11'd201, 32'd12, lat);
        complete("stat_st1");
        issue(1'b0, 11'd1100, 32'd0, lat);
        complete("stat_oor");
        check("stat_loads", {16'd0, stat_loads}, 32'd4);
        check("stat_stores", {16'd0, stat_stores}, 32'd2);
        check("stat_errs", {24'd0, stat_errs}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips32_dmem_responder.md
Name: mips32_dmem_responder

Overview:
- Data-memory responder for the pipe_MIPS32 MEM stage: the memory-side end of the load/store interface.
- Accepts word-addressed LW/SW requests over a valid/ready handshake, inserts a configurable number of wait states, and returns load data and store acknowledges.
- Lets the pipeline run against a timed memory model instead of a zero-latency array.
- Single clock domain; owns the data array.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal addresses are 0..DEPTH-1.
- ADDR_W, 10, request address width; DEPTH must be no greater than 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store (SW), 0 = load (LW).
- req_addr  input  ADDR_W  word address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load data; 0 for stores.
- rsp_err  output  1  address was out of range (req_addr >= DEPTH).
- rsp_was_store  output  1  echoes req_we of the completed request.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_was_store=0.
  - The memory array is not cleared.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, capture we, addr, wdata and set cnt=WAIT_CYCLES.
  - Go to WAIT, or directly to ACCESS if WAIT_CYCLES==0.
- WAIT: req_ready=0. cnt decrements each cycle; at cnt==1 go to ACCESS.
- ACCESS: one cycle.
  - In-range store: Mem[addr]<=wdata.
  - In-range load: rsp_rdata<=Mem[addr].
  - Out of range: no write, rsp_rdata<=0, rsp_err<=1.
  - Next state RESP.
- RESP: rsp_valid=1. rsp_rdata, rsp_err and rsp_was_store are held stable until rsp_ready.
  - On rsp_ready, rsp_valid drops, rsp_err clears and state returns to IDLE.
  - req_ready is 1 again the cycle after.
- Latency: acceptance edge to rsp_valid high is WAIT_CYCLES+2 clk edges.
- One outstanding request maximum. No pipelining of a second request while in WAIT, ACCESS or RESP.
- A store is committed in ACCESS even if rsp_ready never arrives. A later load of the same address returns the new value.
- req_* changes while req_ready=0 are ignored.
- Reset mid-transaction: FSM aborts to IDLE and no response is issued.
  - A store already past ACCESS remains written.
  - A store still in WAIT is dropped.
- Test access: the array is named Mem, so benches may preload and inspect it hierarchically.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, the block adds three output ports:
  - stat_loads (16): count of completed loads.
  - stat_stores (16): count of completed stores.
  - stat_errs (8): count of out-of-range accesses.
- Counting rules:
  - Each counter increments in the RESP handshake cycle.
  - All counters saturate at all-ones and reset to 0 on rst_n.
- When not defined: none of these ports or registers exist, and the rest of the behaviour is identical.

Test Plan:
- Preload Mem[120]=85; load addr 120 with WAIT_CYCLES=2, rsp_ready held 1 -> rsp_valid high exactly 4 edges after acceptance, rsp_rdata=85, rsp_err=0, rsp_was_store=0.
- Store 130 to addr 121, then load 121 -> store response rsp_rdata=0 and rsp_was_store=1; load returns 130; Mem[120] still 85.
- Load addr 1024 with DEPTH=1024 -> rsp_err=1, rsp_rdata=0, no array change; the next in-range response has rsp_err=0.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; handshake then completes and req_ready=1 the next cycle.
- Assert rst_n=0 during WAIT of a store to addr 50 (Mem[50]=7) -> outputs go immediately to reset values, Mem[50] stays 7, no rsp_valid after release.
- With DMEM_STATS_EN: 3 loads, 2 stores, 1 out-of-range load -> stat_loads=4, stat_stores=2, stat_errs=1.
